mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported memory between the unpipelined core's instruction-fetch requester and its load/store requester. It replaces the separate instruction and data memory paths. It arbitrates requests, latches the winner's command, and drives the memory handshake. It then routes the memory response back to the owner as a one-cycle pulse. Only one transaction is outstanding at a time, which matches the core's one-instruction-at-a-time execution.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch command accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched instruction; holds the value until the next if_rvalid
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store
- ls_size  in  2  00 byte, 01 half, 10 word (same encoding as whb)
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  one-cycle pulse: load/store command accepted
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store done
- ls_rdata  out  DW  load data; not updated on store completion
- mem_req  out  1  command valid to memory
- mem_we, mem_size, mem_addr, mem_wdata  out  1/2/AW/DW  latched command
- mem_ready  in  1  memory accepts the command this cycle
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  DW  read data
- busy  out  1  state != IDLE
- err  out  1  sticky: mem_rvalid arrived outside WAIT

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high at the edge, choose the winner, latch its command into the mem_* registers, record the owner, pulse the owner's gnt, and go to ISSUE.
  - A fetch command is latched with mem_we=0 and mem_size=10.
- Arbitration when both req are high:
  - The fixed-priority rule is that ls wins. The in-flight instruction needs its data before the next fetch is meaningful.
  - The round-robin rule applies under the Configuration macro.
- ISSUE:
  - mem_req=1, with the command held stable.
  - On mem_ready=1, go to WAIT.
- WAIT:
  - On mem_rvalid=1, register mem_rdata into the owner's rdata (loads and fetches only), pulse the owner's rvalid next cycle, and go to IDLE.
- Requests are not sampled in ISSUE or WAIT. A requester keeps req high until gnt and may drop it after gnt. The request payload is don't-care after gnt.
- A req that is still high in the same cycle as its own rvalid is treated as a new request.
- err is set by mem_rvalid in IDLE or ISSUE. Such a response is discarded and does not change state. err clears only on reset.
- Reset values:
  - State IDLE.
  - mem_req, all gnt, all rvalid, busy and err = 0.
  - if_rdata, ls_rdata and the mem_* command = 0.
  - Last-owner = ls.
- Reset mid-transaction: abort immediately. No rvalid is produced, and the memory must be reset alongside.

## Timing
- Edge numbers below are rising edges of clk.
- Request seen at edge 0:
  - gnt is high in cycle 1 and mem_req is high from cycle 1.
- If mem_ready=1 in cycle 1 and mem_rvalid=1 in cycle 2:
  - rvalid is high in cycle 3, with rdata valid from cycle 3.
  - The FSM is in IDLE in cycle 3 and can arbitrate at edge 3.
- Minimum spacing is 3 cycles between back-to-back grants.
- mem_ready wait states extend ISSUE, and mem_rvalid delay extends WAIT, cycle for cycle, with no bound.
- gnt and rvalid are registered, never combinational from the inputs.
- mem_* outputs change only on the grant edge.

## Configuration
- MEM_ARB_RR_EN defined:
  - On a tie, the requester that did not win the last grant wins.
  - Last-owner resets to ls, so the first tie after reset goes to if.
- MEM_ARB_RR_EN undefined:
  - Fixed priority, ls always wins ties.
  - The last-owner register is not implemented.

## Test plan
- Single fetch:
  - Stimulus: if_req with if_addr=0x0000_0010; memory mem_ready=1 immediately, mem_rvalid one cycle later with rdata=0x0041_0113.
  - Required: if_gnt in cycle 1, mem_addr=0x10 with mem_we=0, if_rvalid in cycle 3 with if_rdata=0x0041_0113, ls_rvalid never high.
- Store with wait states:
  - Stimulus: ls_we=1, ls_size=01, ls_addr=0x100, ls_wdata=0xBEEF; mem_ready held low 2 cycles; write ack.
  - Required: mem_req high 3 cycles, command stable throughout, ls_rvalid pulses once, ls_rdata stays 0.
- Tie, fixed priority:
  - Stimulus: if_req and ls_req both high at edge 0, both held until granted.
  - Required: ls granted first; if granted at edge 3 (both responses immediate); order ls then if.
- Tie, MEM_ARB_RR_EN:
  - Stimulus: both requesters always asserting, for 4 grants.
  - Required: grant order if, ls, if, ls.
- Error and reset:
  - Stimulus: mem_rvalid pulsed in IDLE; later, rst low during WAIT.
  - Required: err=1 after the first pulse and state unchanged; on reset, all outputs return to reset values, err=0, no rvalid emitted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported memory between the core's instruction-fetch
//   requester (if_*) and its load/store requester (ls_*). A single
//   transaction is outstanding at a time. The FSM arbitrates, latches the
//   winner's command into the mem_* registers, runs the memory handshake,
//   then returns the response to the owner as a one-cycle rvalid pulse.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (the loser of the last
//                               grant wins); last owner resets to ls.
//                  undefined -> fixed priority, ls always wins ties.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_gnt)
//   if_gnt                   one-cycle pulse, fetch command accepted
//   if_rvalid/if_rdata       one-cycle pulse with the fetched word (held)
//   ls_req/ls_we/ls_size/
//   ls_addr/ls_wdata         load/store request (held until ls_gnt)
//   ls_gnt                   one-cycle pulse, load/store command accepted
//   ls_rvalid/ls_rdata       load data valid or store done; rdata held
//   mem_req                  command valid to memory (ISSUE state)
//   mem_we/mem_size/
//   mem_addr/mem_wdata       latched command
//   mem_ready                memory accepts the command
//   mem_rvalid/mem_rdata     memory response
//   busy                     FSM not idle
//   err                      sticky: response seen outside WAIT
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_size,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic any_req;
    logic win_ls;
    logic owner_ls;

    assign any_req = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
    // Remembers who won the previous grant so a tie goes to the other side.
    logic last_ls;

    assign win_ls = ls_req & (~if_req | ~last_ls);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_ls <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_ls <= win_ls;
        end
    end
`else
    // The in-flight instruction needs its data before another fetch helps.
    assign win_ls = ls_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req)    state_next = ISSUE;
            ISSUE:   if (mem_ready)  state_next = WAIT;
            WAIT:    if (mem_rvalid) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // mem_req and busy decode the registered state, so they never depend
    // combinationally on the requesters.
    assign mem_req = (state == ISSUE);
    assign busy    = (state != IDLE);

    // Command latch, owner tracking and registered response pulses. The
    // command registers only load on the grant edge, keeping them stable
    // through ISSUE and WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_ls  <= 1'b0;
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
            mem_we    <= 1'b0;
            mem_size  <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;

            if (mem_rvalid && state != WAIT) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_ls <= win_ls;
                        if (win_ls) begin
                            ls_gnt    <= 1'b1;
                            mem_we    <= ls_we;
                            mem_size  <= ls_size;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                        end else begin
                            if_gnt    <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_size  <= 2'b10;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_ls) begin
                            ls_rvalid <= 1'b1;
                            // Store completion is an ack only; keep the last load data.
                            if (!mem_we) begin
                                ls_rdata <= mem_rdata;
                            end
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Directed bench for mem_port_arbiter. Stimulus pushes the expected grant
//   owners and responses into queues; a monitor pops and compares whenever
//   the DUT pulses a gnt or rvalid. A small memory responder answers mem_req
//   with configurable ready/rvalid delays and address-derived read data.
//   Tie expectations follow MEM_ARB_RR_EN when it is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [1:0]    ls_size;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          err;

    typedef struct packed {
        logic          owner_ls;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    logic gnt_q[$];

    int checks = 0;
    int errors = 0;

    int ready_wait  = 0;
    int rvalid_wait = 0;
    int stray_req   = 0;
    int stray_ack   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_size    (ls_size),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err        (err)
    );

    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] addr);
        if (addr == 32'h0000_0010) return 32'h0041_0113;
        return addr ^ 32'hCAFE_0000;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Memory responder: accepts after ready_wait cycles, answers rvalid_wait
    // cycles after acceptance, and gives up if reset arrives meanwhile.
    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_ack) begin
                stray_ack  = stray_req;
                mem_rdata  = 32'hDEAD_BEEF;
                mem_rvalid = 1'b1;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end else if (rst && mem_req) begin
                for (int k = 0; k < ready_wait; k++) @(negedge clk);
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                for (int k = 0; k < rvalid_wait && rst; k++) @(negedge clk);
                if (rst) begin
                    mem_rdata  = model_data(mem_addr);
                    mem_rvalid = 1'b1;
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        logic exp_ls;
        rsp_t exp_rsp;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (if_gnt || ls_gnt) begin
                    if (gnt_q.size() == 0) begin
                        check_output("unexpected_gnt", {30'b0, if_gnt, ls_gnt}, 32'h0);
                    end else begin
                        exp_ls = gnt_q.pop_front();
                        check_output("gnt_owner", {30'b0, if_gnt, ls_gnt},
                                     exp_ls ? 32'h1 : 32'h2);
                    end
                end
                if (if_rvalid || ls_rvalid) begin
                    if (rsp_q.size() == 0) begin
                        check_output("unexpected_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'h0);
                    end else begin
                        exp_rsp = rsp_q.pop_front();
                        check_output("rvalid_owner", {30'b0, if_rvalid, ls_rvalid},
                                     exp_rsp.owner_ls ? 32'h1 : 32'h2);
                        check_output("rdata", exp_rsp.owner_ls ? ls_rdata : if_rdata,
                                     exp_rsp.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus_reset();
        rst      = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_size  = 2'b00;
        ls_addr  = '0;
        ls_wdata = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int req_cycles;
        int pulses;
        int if_cyc;
        int ls_cyc;
        int ngr;
        int waited;

        apply_stimulus_reset();
        check_output("rst_busy",    {31'b0, busy},    32'h0);
        check_output("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check_output("rst_err",     {31'b0, err},     32'h0);
        check_output("rst_pulses",  {28'b0, if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 32'h0);
        check_output("rst_cmd",     {29'b0, mem_we, mem_size} | mem_addr | mem_wdata, 32'h0);
        check_output("rst_rdata",   if_rdata | ls_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch
        $display("[TB] single fetch");
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        gnt_q.push_back(1'b0);
        rsp_q.push_back('{1'b0, 32'h0041_0113});
        @(negedge clk);
        check_output("fetch_gnt_c1",  {31'b0, if_gnt},  32'h1);
        check_output("fetch_mem_req", {31'b0, mem_req}, 32'h1);
        check_output("fetch_addr",    mem_addr,         32'h0000_0010);
        check_output("fetch_we",      {31'b0, mem_we},  32'h0);
        check_output("fetch_size",    {30'b0, mem_size}, 32'h2);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("fetch_rvalid_c3", {31'b0, if_rvalid}, 32'h1);
        check_output("fetch_idle_c3",   {31'b0, busy},      32'h0);

        // Store with two wait states
        $display("[TB] store with wait states");
        ready_wait = 2;
        @(negedge clk);
        ls_we    = 1'b1;
        ls_size  = 2'b01;
        ls_addr  = 32'h0000_0100;
        ls_wdata = 32'h0000_BEEF;
        ls_req   = 1'b1;
        gnt_q.push_back(1'b1);
        rsp_q.push_back('{1'b1, 32'h0000_0000});
        req_cycles = 0;
        pulses     = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ls_gnt) ls_req = 1'b0;
            if (mem_req) begin
                req_cycles++;
                check_output("store_cmd", {mem_we, mem_size, mem_addr[28:0]},
                             {1'b1, 2'b01, 29'h100});
                check_output("store_wdata", mem_wdata, 32'h0000_BEEF);
            end
            if (ls_rvalid) pulses++;
        end
        check_output("store_req_cycles", req_cycles, 32'd3);
        check_output("store_pulses",     pulses,     32'd1);
        check_output("store_rdata_kept", ls_rdata,   32'h0);
        ready_wait = 0;

        // Tie: both requests held until granted
        $display("[TB] tie, held until granted");
        @(negedge clk);
        ls_we   = 1'b0;
        ls_size = 2'b10;
        ls_addr = 32'h0000_0200;
        if_addr = 32'h0000_0300;
        ls_req  = 1'b1;
        if_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        rsp_q.push_back('{1'b0, 32'hCAFE_0300});
        rsp_q.push_back('{1'b1, 32'hCAFE_0200});
`else
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        rsp_q.push_back('{1'b1, 32'hCAFE_0200});
        rsp_q.push_back('{1'b0, 32'hCAFE_0300});
`endif
        if_cyc = 0;
        ls_cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ls_gnt) begin ls_req = 1'b0; ls_cyc = i; end
            if (if_gnt) begin if_req = 1'b0; if_cyc = i; end
        end
`ifdef MEM_ARB_RR_EN
        check_output("tie_if_cycle", if_cyc, 32'd1);
        check_output("tie_ls_cycle", ls_cyc, 32'd4);
`else
        check_output("tie_ls_cycle", ls_cyc, 32'd1);
        check_output("tie_if_cycle", if_cyc, 32'd4);
`endif

        // Both requesters asserting continuously for four grants
        $display("[TB] continuous contention");
        @(negedge clk);
        ls_addr = 32'h0000_0400;
        if_addr = 32'h0000_0500;
        ls_req  = 1'b1;
        if_req  = 1'b1;
`ifdef MEM_ARB_RR_EN
        for (int g = 0; g < 4; g++) begin
            gnt_q.push_back(g[0]);
            rsp_q.push_back(g[0] ? '{1'b1, 32'hCAFE_0400} : '{1'b0, 32'hCAFE_0500});
        end
`else
        for (int g = 0; g < 4; g++) begin
            gnt_q.push_back(1'b1);
            rsp_q.push_back('{1'b1, 32'hCAFE_0400});
        end
`endif
        ngr = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (if_gnt || ls_gnt) ngr++;
            if (ngr == 4) begin
                ls_req = 1'b0;
                if_req = 1'b0;
            end
        end
        check_output("contention_grants", ngr, 32'd4);

        // Stray response in IDLE
        $display("[TB] stray response and reset in WAIT");
        @(negedge clk);
        stray_req++;
        repeat (3) @(negedge clk);
        check_output("stray_err",  {31'b0, err},  32'h1);
        check_output("stray_idle", {31'b0, busy}, 32'h0);

        // Reset while waiting for the response
        rvalid_wait = 20;
        if_addr = 32'h0000_0600;
        if_req  = 1'b1;
        gnt_q.push_back(1'b0);
        waited = 0;
        while (!if_gnt && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if_req = 1'b0;
        check_output("abort_gnt_seen", {31'b0, if_gnt}, 32'h1);
        waited = 0;
        while (!(busy && !mem_req) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output("abort_in_wait", {31'b0, busy && !mem_req}, 32'h1);
        rst = 1'b0;
        #1;
        check_output("abort_busy",  {31'b0, busy},    32'h0);
        check_output("abort_err",   {31'b0, err},     32'h0);
        check_output("abort_req",   {31'b0, mem_req}, 32'h0);
        check_output("abort_cmd",   {29'b0, mem_we, mem_size} | mem_addr, 32'h0);
        check_output("abort_rdata", if_rdata | ls_rdata, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) pulses++;
        end
        check_output("abort_no_rvalid", pulses, 32'd0);
        check_output("abort_err_after", {31'b0, err}, 32'h0);
        rvalid_wait = 0;

        check_output("gnt_q_empty", gnt_q.size(), 32'd0);
        check_output("rsp_q_empty", rsp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
